// File: rtl/demux1x4_stream.sv
// ---------------------------------------------------------------------------
// demux1x4_stream
//
// Registered 1-to-4 stream demultiplexer. One valid/ready input stream feeds
// four independent output channels. in_sel picks the channel for each word.
// Every channel has a one-deep output slot. A stalled channel therefore holds
// back only the words addressed to it. Each channel also keeps a saturating
// transfer counter for debug and status.
//
// Handshake rule, used on the input and on every output channel:
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   While valid = 1 and ready = 0, the producer keeps its data and valid
//   stable. valid never waits for ready. ready may depend combinationally on
//   the state of the destination slot and on that slot's sink ready.
//
// Parameters:
//   DW  data width of each word
//   CW  width of each per-channel transfer counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel for in_data (0..3)
//   in_valid   input word present
//   in_ready   block can accept the input word this cycle
//   out_data   channel k data at out_data[k*DW +: DW]
//   out_valid  per-channel valid
//   out_ready  per-channel ready from the sinks
//   cnt_clr    synchronous clear of all transfer counters
//   cnt        channel k transfer count at cnt[k*CW +: CW]
// ---------------------------------------------------------------------------
module demux1x4_stream #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*DW-1:0] out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    input  logic            cnt_clr,
    output logic [4*CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [3:0] slot_valid;
    logic [3:0] drain;
    logic [3:0] load;
    logic       accept;

    // The selected slot can take a word if it is empty. It can also take one
    // if it is draining this same edge, which gives one word per cycle per
    // channel.
    assign in_ready = !slot_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;
    assign drain    = slot_valid & out_ready;

    // At most one slot loads per cycle: a one-hot of in_sel, gated by accept.
    always_comb begin
        load         = '0;
        load[in_sel] = accept;
    end

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic          v_q;
        logic [DW-1:0] d_q;
        logic [CW-1:0] c_q;

        // A load takes priority over a drain. A same-edge drain+load keeps
        // the slot full with the new word. A drain alone empties the slot,
        // and the data register keeps its last value.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (load[k]) begin
                v_q <= 1'b1;
                d_q <= in_data;
            end else if (drain[k]) begin
                v_q <= 1'b0;
            end
        end

        // Clear beats a same-cycle handshake. The counter sticks at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= '0;
            end else if (cnt_clr) begin
                c_q <= '0;
            end else if (drain[k] && (c_q != CNT_MAX)) begin
                c_q <= c_q + 1'b1;
            end
        end

        assign slot_valid[k]          = v_q;
        assign out_data[k*DW +: DW]   = d_q;
        assign cnt[k*CW +: CW]        = c_q;
    end

    assign out_valid = slot_valid;

endmodule

// File: tb/tb_demux1x4_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1x4_stream
//
// Bench for demux1x4_stream. Two instances share one set of inputs:
//   dut   uses CW=8
//   dut4  uses CW=4, so counter saturation shows up after 15 transfers
// A negedge scoreboard keeps one expected queue per channel and a counter
// model for each instance. On top of that, directed table rows and
// hand-written sequences carry hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_demux1x4_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic        cnt_clr;
    logic [31:0] cnt;

    logic        in_ready4;
    logic [31:0] out_data4;
    logic [3:0]  out_valid4;
    logic [15:0] cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    demux1x4_stream #(.DW(8), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .cnt(cnt)
    );

    demux1x4_stream #(.DW(8), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .cnt(cnt4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [4][$];
    int m_cnt  [4];
    int m_cnt4 [4];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                exp_q[k].delete();
                m_cnt[k]  = 0;
                m_cnt4[k] = 0;
            end
        end else begin
            logic       m_rdy;
            logic [3:0] m_drain;
            // Compare the state left by the previous edge.
            for (int k = 0; k < 4; k++) begin
                check("sb_valid", {31'd0, out_valid[k]}, {31'd0, exp_q[k].size() != 0});
                check("sb_valid4", {31'd0, out_valid4[k]}, {31'd0, exp_q[k].size() != 0});
                if (exp_q[k].size() != 0) begin
                    check("sb_data", {24'd0, out_data[k*8 +: 8]}, {24'd0, exp_q[k][0]});
                    check("sb_data4", {24'd0, out_data4[k*8 +: 8]}, {24'd0, exp_q[k][0]});
                end
                check("sb_cnt", {24'd0, cnt[k*8 +: 8]}, m_cnt[k]);
                check("sb_cnt4", {28'd0, cnt4[k*4 +: 4]}, m_cnt4[k]);
            end
            m_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
            check("sb_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
            check("sb_in_ready4", {31'd0, in_ready4}, {31'd0, m_rdy});
            // Predict the coming edge: drains first (older words), then the load.
            for (int k = 0; k < 4; k++) begin
                m_drain[k] = (exp_q[k].size() != 0) && out_ready[k];
                if (m_drain[k]) void'(exp_q[k].pop_front());
                if (cnt_clr) begin
                    m_cnt[k]  = 0;
                    m_cnt4[k] = 0;
                end else if (m_drain[k]) begin
                    if (m_cnt[k] < 255) m_cnt[k]++;
                    if (m_cnt4[k] < 15) m_cnt4[k]++;
                end
            end
            if (in_valid && m_rdy) exp_q[in_sel].push_back(in_data);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] r, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        cnt_clr   = c;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic        chk_d;
        logic [1:0]  chk_ch;
        logic [7:0]  exp_d;
        logic        chk_c;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // Basic steer: one word to each channel, all sinks ready.
        tbl[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1, 32'h01010101};
        // Backpressure on ch2: ch0 keeps flowing while ch2 is stalled.
        tbl[6]  = '{1'b1, 2'd2, 8'h55, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 8'h66, 4'b1011, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 2'd0, 8'h77, 4'b1011, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 2'd2, 8'h66, 4'b1011, 1'b0, 4'b0101, 1'b1, 2'd0, 8'h77, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 2'd2, 8'h66, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h55, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h66, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h66, 1'b1, 32'h01030102};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        cnt_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {28'd0, out_valid}, 32'h0);
        check("reset_data", out_data, 32'h0);
        check("reset_cnt", cnt, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table-driven rows: apply after the edge, compare at the negedge.
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
            check($sformatf("tbl%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].exp_ov});
            if (tbl[i].chk_d)
                check($sformatf("tbl%0d_out_data", i), {24'd0, out_data[tbl[i].chk_ch*8 +: 8]},
                      {24'd0, tbl[i].exp_d});
            if (tbl[i].chk_c)
                check($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
        end

        // Full throughput on ch3: 16 back-to-back words after a clear.
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 2'd3, i[7:0], 4'hF, 1'b0);
            @(negedge clk);
            check("thru_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        @(negedge clk);
        check("thru_cnt3", {24'd0, cnt[31:24]}, 32'd16);
        check("thru_cnt3_sat4", {28'd0, cnt4[15:12]}, 32'd15);
        check("thru_cnt_others", {8'd0, cnt[23:0]}, 32'd0);

        // Saturation on ch1, then clear racing a handshake.
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b1);
        for (int i = 0; i <= 20; i++) drive(1'b1, 2'd1, 8'h80 + i[7:0], 4'hF, 1'b0);
        drive(1'b0, 2'd1, 8'h00, 4'hF, 1'b1);
        @(negedge clk);
        check("sat_cnt1_cw4", {28'd0, cnt4[7:4]}, 32'd15);
        check("sat_cnt1_cw8", {24'd0, cnt[15:8]}, 32'd20);
        check("clr_drain_valid", {31'd0, out_valid[1]}, 32'd1);
        drive(1'b1, 2'd1, 8'hEE, 4'hF, 1'b0);
        @(negedge clk);
        check("clr_wins_cw4", {28'd0, cnt4[7:4]}, 32'd0);
        check("clr_wins_cw8", {24'd0, cnt[15:8]}, 32'd0);
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        @(negedge clk);
        check("after_clr_cw4", {28'd0, cnt4[7:4]}, 32'd1);
        check("after_clr_cw8", {24'd0, cnt[15:8]}, 32'd1);

        // Reset mid-run with slots 1 and 2 full and stalled.
        drive(1'b1, 2'd1, 8'h11, 4'b1001, 1'b0);
        drive(1'b1, 2'd2, 8'h22, 4'b1001, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        #1;
        check("pre_rst_valid", {28'd0, out_valid}, 32'h6);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {28'd0, out_valid}, 32'h0);
        check("rst_async_cnt", cnt, 32'h0);
        check("rst_async_cnt4", {16'd0, cnt4}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = s[1:0];
            #1;
            check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        end

        // Random soak. The scoreboard checks every cycle.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
        end
        // Drain everything still in flight.
        repeat (3) drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
        @(negedge clk);
        check("soak_drained", {28'd0, out_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux1x4_stream.md
Name: demux1x4_stream

Overview:
- Registered 1-to-4 stream demultiplexer, the distribution counterpart of the 4-to-1 mux path.
- Takes a single valid/ready input stream and steers each word to one of four output channels selected by sel.
- Each output channel has its own one-deep output register, so a stalled channel blocks only words addressed to it.
- Keeps per-channel saturating transfer counters for debug and status.

Parameters:
- DW, 8, data width of each word.
- CW, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DW  input word.
- in_sel  input  2  destination channel for in_data; 0..3 map to out channels 0..3.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- out_data  output  4*DW  channel k data is out_data[k*DW +: DW].
- out_valid  output  4  per-channel valid.
- out_ready  input  4  per-channel ready from the sinks.
- cnt_clr  input  1  synchronous clear of all transfer counters.
- cnt  output  4*CW  channel k count is cnt[k*CW +: CW].

Behaviour:
- Reset: asynchronous on rst_n low.
  - out_valid = 0, out_data = 0, cnt = 0.
  - in_ready follows its combinational equation. With all slots empty it is 1, but no word is accepted while rst_n is low.
- Slot k empty/full is defined by out_valid[k].
- in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - Combinational; depends only on in_sel and the state and ready of the selected slot.
  - It is defined even when in_valid = 0.
- Accept: in_valid & in_ready at a rising edge loads slot in_sel.
  - out_data[in_sel] <= in_data and out_valid[in_sel] <= 1.
  - Latency is 1 cycle: the word is visible on the output the cycle after acceptance.
- Drain: out_valid[k] & out_ready[k] at an edge completes the transfer on channel k.
  - If slot k is not loaded in the same cycle, out_valid[k] <= 0.
  - out_data[k] holds its last value.
- Simultaneous drain and load of the same slot: out_valid stays 1 and out_data takes the new word. Full throughput is one word per cycle per channel.
- Channels are independent:
  - Drains on several channels can occur in the same cycle.
  - At most one load occurs per cycle.
- While out_valid[k] = 1 and out_ready[k] = 0, out_data[k] and out_valid[k] are held stable (no overwrite, no drop).
- in_sel and in_data are sampled only on accept. Other slots are unaffected by in_sel changes.
- Counters: cnt[k] increments by 1 on each channel-k output handshake.
  - Saturates at 2^CW-1 and does not wrap.
  - cnt_clr = 1 sets all counters to 0 at the edge.
  - If cnt_clr and a handshake occur in the same cycle, clear wins and the result is 0.
- Reset mid-transfer: all pending slot contents are discarded and out_valid drops immediately, without waiting for clk.
- No ordering guarantee across channels. Within a channel, word order is preserved.

Test Plan:
- Reset/idle:
  - Assert rst_n=0 mid-run with slots 1 and 2 full.
  - Required: out_valid=4'b0000 immediately, cnt all 0.
  - After release with in_valid=0: in_ready=1 for every in_sel.
- Basic steer:
  - Send 8'hA0, 8'hA1, 8'hA2, 8'hA3 with in_sel=0,1,2,3 on consecutive cycles, out_ready=4'hF.
  - Required: each word appears on its channel exactly 1 cycle after acceptance.
  - Required: cnt = 1,1,1,1.
- Backpressure isolation:
  - Set out_ready[2]=0, send 8'h55 to ch2, then 8'h66 to ch2, then 8'h77 to ch0.
  - Required: out_data[2] holds 8'h55, and in_ready=0 while in_sel=2 with 8'h66 pending.
  - Required: 8'h77 is accepted and appears on ch0.
  - Release out_ready[2]: 8'h66 loads in the same cycle 8'h55 drains.
- Full-throughput same channel:
  - Stream 8'h01..8'h10 to ch3 back-to-back with out_ready[3]=1.
  - Required: in_ready stays 1, 16 consecutive output handshakes in order, cnt[3]=16.
- Counter saturation and clear:
  - With CW=4, drive 20 handshakes on ch1. Required: cnt[1]=15.
  - Assert cnt_clr together with a ch1 handshake. Required: cnt[1]=0 the next cycle.
  - Next handshake gives cnt[1]=1.
- Random soak:
  - Random in_sel, in_valid and per-channel out_ready for 10k cycles.
  - Required: a scoreboard shows no loss, duplication or reordering within a channel.
  - Required: each cnt matches the scoreboard, saturated at 2^CW-1 and zeroed by each cnt_clr.
